// File: rtl/hazard_ctrl_pipe.sv
// Hazard detection, MDU occupancy and forwarding control for the
// 5-stage MIPS core: D decode, E/M/W destination bundles, stall/fwd.

package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_NONE = 2'd0,
        MDU_MULT = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_op_e;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       regwr;
        mdu_op_e    mdu_op;
    } stage_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
    } src_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

endpackage

module hazard_ctrl_pipe #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    output logic        stall,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        RegWr_W,
    output logic [4:0]  A3_W
);

    import hazard_ctrl_pkg::*;

    logic [5:0] op_d;
    logic [5:0] fn_d;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rd_d;

    assign op_d = Instr_D[31:26];
    assign rs_d = Instr_D[25:21];
    assign rt_d = Instr_D[20:16];
    assign rd_d = Instr_D[15:11];
    assign fn_d = Instr_D[5:0];

    logic is_rtype;
    logic is_addu, is_subu, is_jr;
    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic is_ori, is_lui, is_beq, is_jal;
    logic is_lw, is_lb, is_lh, is_sw, is_sb, is_sh;

    assign is_rtype = (op_d == OP_RTYPE);
    assign is_addu  = is_rtype && (fn_d == FN_ADDU);
    assign is_subu  = is_rtype && (fn_d == FN_SUBU);
    assign is_jr    = is_rtype && (fn_d == FN_JR);
    assign is_mult  = is_rtype && (fn_d == FN_MULT);
    assign is_multu = is_rtype && (fn_d == FN_MULTU);
    assign is_div   = is_rtype && (fn_d == FN_DIV);
    assign is_divu  = is_rtype && (fn_d == FN_DIVU);
    assign is_mfhi  = is_rtype && (fn_d == FN_MFHI);
    assign is_mflo  = is_rtype && (fn_d == FN_MFLO);
    assign is_mthi  = is_rtype && (fn_d == FN_MTHI);
    assign is_mtlo  = is_rtype && (fn_d == FN_MTLO);
    assign is_ori   = (op_d == OP_ORI);
    assign is_lui   = (op_d == OP_LUI);
    assign is_beq   = (op_d == OP_BEQ);
    assign is_jal   = (op_d == OP_JAL);
    assign is_lw    = (op_d == OP_LW);
    assign is_lb    = (op_d == OP_LB);
    assign is_lh    = (op_d == OP_LH);
    assign is_sw    = (op_d == OP_SW);
    assign is_sb    = (op_d == OP_SB);
    assign is_sh    = (op_d == OP_SH);

    logic is_alu_r, is_load, is_store;
    logic is_md_mul, is_md_div, is_md_calc;
    logic is_md_from, is_md_to, is_md_any;

    assign is_alu_r   = is_addu | is_subu;
    assign is_load    = is_lw | is_lb | is_lh;
    assign is_store   = is_sw | is_sb | is_sh;
    assign is_md_mul  = is_mult | is_multu;
    assign is_md_div  = is_div | is_divu;
    assign is_md_calc = is_md_mul | is_md_div;
    assign is_md_from = is_mfhi | is_mflo;
    assign is_md_to   = is_mthi | is_mtlo;
    assign is_md_any  = is_md_calc | is_md_from | is_md_to;

    logic [4:0] dec_a3;
    logic [1:0] dec_tnew;
    logic       dec_wr;
    mdu_op_e    dec_md;
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;

    // j and every undecoded encoding fall to the default: a pure nop
    always_comb begin
        dec_a3   = 5'd0;
        dec_tnew = 2'd0;
        dec_wr   = 1'b0;
        dec_md   = MDU_NONE;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        tuse_rs  = 2'd0;
        tuse_rt  = 2'd0;
        unique case (1'b1)
            is_alu_r: begin
                dec_a3   = rd_d;
                dec_tnew = 2'd1;
                dec_wr   = 1'b1;
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
                use_rt   = 1'b1;
                tuse_rt  = 2'd1;
            end
            is_ori: begin
                dec_a3   = rt_d;
                dec_tnew = 2'd1;
                dec_wr   = 1'b1;
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
            end
            is_lui: begin
                dec_a3   = rt_d;
                dec_tnew = 2'd1;
                dec_wr   = 1'b1;
            end
            is_load: begin
                dec_a3   = rt_d;
                dec_tnew = 2'd2;
                dec_wr   = 1'b1;
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
            end
            is_store: begin
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
                use_rt   = 1'b1;
                tuse_rt  = 2'd2;
            end
            is_beq: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
            end
            is_jal: begin
                dec_a3   = 5'd31;
                dec_wr   = 1'b1;
            end
            is_jr: begin
                use_rs   = 1'b1;
            end
            is_md_calc: begin
                dec_md   = is_md_div ? MDU_DIV : MDU_MULT;
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
                use_rt   = 1'b1;
                tuse_rt  = 2'd1;
            end
            is_md_from: begin
                dec_a3   = rd_d;
                dec_tnew = 2'd1;
                dec_wr   = 1'b1;
            end
            is_md_to: begin
                use_rs   = 1'b1;
                tuse_rs  = 2'd1;
            end
            default: ;
        endcase
    end

    stage_t dec_bundle;

    always_comb begin
        dec_bundle        = '0;
        dec_bundle.a3     = dec_a3;
        dec_bundle.tnew   = dec_tnew;
        dec_bundle.regwr  = dec_wr && (dec_a3 != 5'd0);
        dec_bundle.mdu_op = dec_md;
    end

    stage_t          e_q, e_d;
    stage_t          m_q, m_d;
    stage_t          w_q, w_d;
    src_t            src_e_q, src_e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic writes(input stage_t s, input logic [4:0] r);
        return s.regwr && (s.a3 != 5'd0) && (s.a3 == r);
    endfunction

    function automatic logic hazard(
        input stage_t     s,
        input logic [4:0] r,
        input logic       used,
        input logic [1:0] tuse
    );
        return used && writes(s, r) && (tuse < s.tnew);
    endfunction

    function automatic logic ready(input stage_t s, input logic [4:0] r);
        return writes(s, r) && (s.tnew == 2'd0);
    endfunction

    logic data_stall;
    logic mdu_stall;

    assign data_stall = hazard(e_q, rs_d, use_rs, tuse_rs)
                      | hazard(e_q, rt_d, use_rt, tuse_rt)
                      | hazard(m_q, rs_d, use_rs, tuse_rs)
                      | hazard(m_q, rt_d, use_rt, tuse_rt);

    assign mdu_start = (e_q.mdu_op != MDU_NONE);
    assign mdu_busy  = (cnt_q != '0);
    assign mdu_stall = is_md_any && (mdu_start || mdu_busy);
    assign stall     = data_stall | mdu_stall;

    always_comb begin
        fwd_rs_D = FWD_NONE;
        if (ready(e_q, rs_d))      fwd_rs_D = FWD_E;
        else if (ready(m_q, rs_d)) fwd_rs_D = FWD_M;
        else if (ready(w_q, rs_d)) fwd_rs_D = FWD_W;
    end

    always_comb begin
        fwd_rt_D = FWD_NONE;
        if (ready(e_q, rt_d))      fwd_rt_D = FWD_E;
        else if (ready(m_q, rt_d)) fwd_rt_D = FWD_M;
        else if (ready(w_q, rt_d)) fwd_rt_D = FWD_W;
    end

    always_comb begin
        fwd_rs_E = FWD_NONE;
        if (ready(m_q, src_e_q.rs))      fwd_rs_E = FWD_M;
        else if (ready(w_q, src_e_q.rs)) fwd_rs_E = FWD_W;
    end

    always_comb begin
        fwd_rt_E = FWD_NONE;
        if (ready(m_q, src_e_q.rt))      fwd_rt_E = FWD_M;
        else if (ready(w_q, src_e_q.rt)) fwd_rt_E = FWD_W;
    end

    always_comb begin
        e_d     = dec_bundle;
        src_e_d = '{rs: rs_d, rt: rt_d};
        if (stall) begin
            e_d     = '0;
            src_e_d = '0;
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
    end

    // A stalled D never blocks the start: E already holds the MDU op
    always_comb begin
        cnt_d = cnt_q;
        if (mdu_start) begin
            if (e_q.mdu_op == MDU_DIV) cnt_d = CNT_W'(DIV_CYCLES);
            else                       cnt_d = CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            src_e_q <= '0;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            src_e_q <= src_e_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RegWr_W = w_q.regwr;
    assign A3_W    = w_q.a3;

    logic unused_bits;
    assign unused_bits = ^{Instr_D[10:6], w_q.mdu_op};

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage MIPS core.
- Succeeds the purely combinational D-stage decoder.
- Decodes the D-stage instruction's register usage and carries destination/Tnew bundles through E, M and W.
- Raises stall on Tuse/Tnew conflicts and on multi-cycle multiply/divide occupancy, and produces forwarding selects for D and E.

Parameters:
MULT_CYCLES, 5, busy cycles after mult/multu leaves E (≥1)
DIV_CYCLES, 10, busy cycles after div/divu leaves E (≥1)
CNT_W, 4, width of MDU busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
Instr_D  in  32  instruction in D stage
stall  out  1  freeze PC and D register; insert bubble into E
fwd_rs_D  out  2  D rs source: 0 regfile, 1 E, 2 M, 3 W
fwd_rt_D  out  2  D rt source, same encoding
fwd_rs_E  out  2  E rs source: 0 pipe reg, 2 M, 3 W
fwd_rt_E  out  2  E rt source, same encoding
mdu_start  out  1  E holds mult/multu/div/divu this cycle
mdu_busy  out  1  MDU counter non-zero
RegWr_W  out  1  W-stage register write enable
A3_W  out  5  W-stage destination register

Behaviour:
- Decoded set: addu, subu, ori, lui, lw, lb, lh, sw, sb, sh, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Anything else is a nop: RegWr=0, no Tuse.
- Destination A3:
  - rt for ori, lui and loads.
  - 31 for jal.
  - rd for addu, subu, mfhi, mflo.
  - A3=0 forces RegWr=0.
- Tnew on E entry: 0 for jal/lui-free path jal only; 1 for ALU ops and mfhi/mflo; 2 for loads.
- Tuse for rs: 0 for beq and jr; 1 for ALU, load, store and MDU ops.
- Tuse for rt: 0 for beq; 1 for addu, subu and MDU ops; 2 for stores. Unused fields carry no Tuse.
- Stage bundles {A3, Tnew(2b), RegWr, mdu_op} are registered E, M and W.
  - E loads the decoded D bundle, or a zero bundle when stall=1.
  - M loads E with Tnew decremented, saturating at 0.
  - W loads M with Tnew decremented, saturating at 0.
- Data stall, for X in {E, M}: RegWr_X, A3_X≠0, A3_X equals the D source register, and Tuse < Tnew_X.
- MDU stall: D is an MDU op and (mdu_start or mdu_busy).
- stall = OR of all stall terms. It is combinational from Instr_D and registered state.
- Forwarding to D:
  - A stage qualifies if RegWr, A3≠0, A3 matches and Tnew=0.
  - Nearest stage wins: E > M > W.
- Forwarding to E:
  - Same qualification against the E instruction's rs/rt.
  - Priority M > W.
  - The E instruction's rs/rt are held in a 10-bit register loaded alongside the E bundle and zeroed on bubble.
- MDU counter:
  - When mdu_start, it loads MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) at the next edge.
  - Otherwise it decrements while non-zero.
  - mdu_busy = (counter≠0).
- Simultaneous events:
  - A stall in the same cycle as mdu_start still loads the counter.
  - A bubble never starts the MDU.
- Reset, asynchronous:
  - All bundles, rs/rt registers and the counter go to 0.
  - stall=0 for any Instr_D.
  - fwd_*=0, mdu_start=0, mdu_busy=0, RegWr_W=0, A3_W=0.
  - Reset mid-divide aborts busy immediately.

Test Plan:
- lw $8,0($0) then addu $9,$8,$8: stall=1 for exactly 1 cycle. Next cycle fwd_rs_D=0 and stall=0. At E, fwd_rs_E=3 (lw in W).
- addu $8,.. then beq $8,$0: stall=1 one cycle (Tnew_E=1>0). Then fwd_rs_D=2 and stall=0.
- jal then jr $31: no stall; fwd_rs_D=1 in the cycle jr is in D.
- mult then mflo: mdu_start=1 in cycle t, counter=5 at t+1. mdu_busy=1 for t+1..t+5. stall=1 for t..t+5 (6 cycles), mflo enters E at t+6.
- addu $0,$1,$2 then addu $3,$0,$0: no stall, all fwd_*=0.
- Assert reset during a div with counter=7: mdu_busy=0 and stall=0 asynchronously. After release, A3_W=0 and RegWr_W=0.
